// File: rtl/p3_shifter_pkg.sv
// Shared op codes and FSM state encoding for the sequential shifter.
package p3_shifter_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/p3_shift_step.sv
// Combinational one-bit shift step; latency 0, no handshake.
// ROR case exists only when P3_SHIFTER_ROT_EN is defined; unknown ops pass through.
module p3_shift_step
  import p3_shifter_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              bit_out
);

  always_comb begin
    q       = d;
    bit_out = 1'b0;
    case (op)
      OP_LSL: begin
        q       = {d[DATA_W-2:0], 1'b0};
        bit_out = d[DATA_W-1];
      end
      OP_LSR: begin
        q       = {1'b0, d[DATA_W-1:1]};
        bit_out = d[0];
      end
      OP_ASR: begin
        q       = {d[DATA_W-1], d[DATA_W-1:1]};
        bit_out = d[0];
      end
`ifdef P3_SHIFTER_ROT_EN
      OP_ROR: begin
        q       = {d[0], d[DATA_W-1:1]};
        bit_out = d[0];
      end
`endif
      default: begin
        q       = d;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/p3_seq_shifter.sv
// Multi-cycle shifter, one bit per clock; done N+1 cycles after start (1 for amt==0/pass).
// start ignored while busy; P3_SHIFTER_ROT_EN enables op 100 (rotate right).
module p3_seq_shifter
  import p3_shifter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  amt,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              carry
);

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [AMT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] step_q;
  logic              step_bit;
  logic [2:0]        op_dec;

  // Fold undefined op codes into pass so the FSM never enters SHIFT for them.
  always_comb begin
    op_dec = OP_PASS;
    case (op)
      OP_LSL, OP_LSR, OP_ASR: op_dec = op;
`ifdef P3_SHIFTER_ROT_EN
      OP_ROR:                 op_dec = op;
`endif
      default:                op_dec = OP_PASS;
    endcase
  end

  p3_shift_step #(.DATA_W(DATA_W)) u_step (
    .op      (op_q),
    .d       (sh),
    .q       (step_q),
    .bit_out (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_PASS;
      cnt   <= '0;
      sh    <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh    <= din;
            op_q  <= op_dec;
            cnt   <= amt;
            carry <= 1'b0;
            state <= (amt != '0 && op_dec != OP_PASS) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          sh    <= step_q;
          carry <= step_bit;
          cnt   <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1))
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign dout = sh;

endmodule

// File: tb/tb_p3_seq_shifter.sv
// Directed self-checking bench for p3_seq_shifter at DATA_W=16.
module tb_p3_seq_shifter;
  import p3_shifter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  amt;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic        carry;

  int passed = 0;
  int total  = 0;

  p3_seq_shifter #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one op, measure cycles from the accepting edge to done, then check the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] exp_dout,
                        input logic exp_carry, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; amt = a; din = d;
    @(posedge clk); #1;
    start = 1'b0; din = 16'h0000; amt = 4'd0; op = OP_PASS;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},   lat,       exp_lat);
    chk({tag, "_dout"},  dout,      exp_dout);
    chk({tag, "_carry"}, carry,     exp_carry);
    chk({tag, "_busy"},  busy,      1'b1);
    @(posedge clk); #1;
    chk({tag, "_idle"},  {busy, done}, 2'b00);
    chk({tag, "_hold"},  dout,      exp_dout);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_PASS; amt = 4'd0; din = 16'h0000;
    #1;
    chk("rst_outs", {busy, done, dout, carry}, 19'h0);
    #20;
    @(negedge clk) reset = 1'b0;

    // Reset while mid-way through an LSL 8
    @(negedge clk);
    start = 1'b1; op = OP_LSL; amt = 4'd8; din = 16'h01FF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {busy, done, dout, carry}, 19'h0);
    @(negedge clk) reset = 1'b0;
    run_op("post_rst_lsl8", OP_LSL, 4'd8, 16'h01FF, 16'hFF00, 1'b1, 9);

    run_op("lsl4",  OP_LSL,  4'd4,  16'h1234, 16'h2340, 1'b1, 5);
    run_op("asr3",  OP_ASR,  4'd3,  16'hF234, 16'hFE46, 1'b1, 4);
    run_op("lsr15", OP_LSR,  4'd15, 16'h8000, 16'h0001, 1'b0, 16);
    run_op("lsr0",  OP_LSR,  4'd0,  16'hBEEF, 16'hBEEF, 1'b0, 1);
    run_op("pass7", OP_PASS, 4'd7,  16'hBEEF, 16'hBEEF, 1'b0, 1);
    run_op("undef", 3'b101,  4'd3,  16'h5A5A, 16'h5A5A, 1'b0, 1);
`ifdef P3_SHIFTER_ROT_EN
    run_op("ror4",  OP_ROR,  4'd4,  16'h1234, 16'h4123, 1'b0, 5);
`else
    run_op("ror4",  OP_ROR,  4'd4,  16'h1234, 16'h1234, 1'b0, 1);
`endif

    // Starts during busy and in the DONE cycle are ignored; next cycle's start is taken
    @(negedge clk);
    start = 1'b1; op = OP_LSL; amt = 4'd2; din = 16'h0003;
    @(posedge clk); #1;
    chk("b2b_busy0", {busy, done}, 2'b10);
    start = 1'b1; op = OP_LSR; amt = 4'd1; din = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done1",  done,  1'b1);
    chk("b2b_dout1",  dout,  16'h000C);
    chk("b2b_carry1", carry, 1'b0);
    start = 1'b1; op = OP_LSR; amt = 4'd1; din = 16'hFFFF;
    @(posedge clk); #1;
    chk("b2b_ignored", {busy, done}, 2'b00);
    chk("b2b_dout_kept", dout, 16'h000C);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", {busy, done}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_done2",  done,  1'b1);
    chk("b2b_dout2",  dout,  16'h7FFF);
    chk("b2b_carry2", carry, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
